// File: rtl/frame_write_ctrl_pkg.sv
// frame_write_ctrl_pkg: shared state encoding and default geometry for the frame write controller.
package frame_write_ctrl_pkg;
   localparam int DEF_DEPTH  = 76800;
   localparam int DEF_ADDR_W = 17;
   typedef logic [1:0] state_t;
   localparam state_t ST_FROZEN  = 2'd0;
   localparam state_t ST_ARMED   = 2'd1;
   localparam state_t ST_CAPTURE = 2'd2;
endpackage

// File: rtl/edge_detect.sv
// edge_detect: registers a level once and flags its rising and falling edges.
module edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic sig_i,
   output logic fall_o,
   output logic rise_o
);
   logic sig_q, primed_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sig_q    <= 1'b1;
         primed_q <= 1'b0;
      end else begin
         sig_q    <= sig_i;
         primed_q <= 1'b1;
      end
   end
   // No edge on the first clock after reset, so a frame already in progress is not mistaken for a new one.
   assign fall_o = primed_q & sig_q & ~sig_i;
   assign rise_o = primed_q & ~sig_q & sig_i;
endmodule

// File: rtl/frame_write_ctrl.sv
// frame_write_ctrl: gates camera pixel writes into a frame buffer under live/freeze/snapshot control.
module frame_write_ctrl
   import frame_write_ctrl_pkg::*;
#(
   parameter int DEPTH  = DEF_DEPTH,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              pclk,
   input  logic              rst,
   input  logic              vsync,
   input  logic              we_in,
   input  logic [ADDR_W-1:0] addr_in,
   input  logic              cmd_live,
   input  logic              cmd_freeze,
   input  logic              cmd_snap,
   output logic              wea,
   output logic [ADDR_W-1:0] addra,
   output logic              frame_done,
   output logic              frozen,
   output logic              overflow,
   output logic [7:0]        frame_cnt
);
   localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);
   state_t state_q, state_d, st_c;
   logic live_q, live_d, more_q, more_d, ovf_q, ovf_d;
   logic wea_q, done_q, frozen_q, fin;
   logic [ADDR_W-1:0] addra_q;
   logic [7:0] cnt_q;
   logic vs_fall, vs_rise, wr_cap, in_rng;
   edge_detect u_vs (
      .clk   (pclk),
      .rst   (rst),
      .sig_i (vsync),
      .fall_o(vs_fall),
      .rise_o(vs_rise)
   );
   assign wr_cap = we_in && (state_q == ST_CAPTURE);
   assign in_rng = {1'b0, addr_in} < LIMIT;
   // Commands resolve first; the vsync edge then acts on the updated state and mode bits.
   always_comb begin
      st_c   = state_q;
      live_d = live_q;
      more_d = more_q;
      ovf_d  = ovf_q;
      if (cmd_freeze) begin
         live_d = 1'b0;
         more_d = 1'b0;
         st_c   = (state_q == ST_ARMED) ? ST_FROZEN : state_q;
      end else if (cmd_snap) begin
         live_d = 1'b0;
         ovf_d  = 1'b0;
         more_d = more_q | (state_q == ST_CAPTURE);
         st_c   = (state_q == ST_FROZEN) ? ST_ARMED : state_q;
      end else if (cmd_live) begin
         live_d = 1'b1;
         more_d = 1'b0;
         ovf_d  = 1'b0;
         st_c   = (state_q == ST_FROZEN) ? ST_ARMED : state_q;
      end
      if (wr_cap && !in_rng) ovf_d = 1'b1;
      fin     = vs_rise && (st_c == ST_CAPTURE);
      state_d = (vs_fall && st_c == ST_ARMED) ? ST_CAPTURE :
                fin ? ((live_d || more_d) ? ST_ARMED : ST_FROZEN) : st_c;
      if (fin) more_d = 1'b0;
   end
   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_ARMED;
         live_q   <= 1'b1;
         more_q   <= 1'b0;
         ovf_q    <= 1'b0;
         wea_q    <= 1'b0;
         addra_q  <= '0;
         done_q   <= 1'b0;
         frozen_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         live_q   <= live_d;
         more_q   <= more_d;
         ovf_q    <= ovf_d;
         wea_q    <= wr_cap && in_rng;
         addra_q  <= addr_in;
         done_q   <= fin;
         frozen_q <= (state_q == ST_FROZEN);
         cnt_q    <= cnt_q + 8'(fin);
      end
   end
   assign wea        = wea_q;
   assign addra      = addra_q;
   assign frame_done = done_q;
   assign frozen     = frozen_q;
   assign overflow   = ovf_q;
   assign frame_cnt  = cnt_q;
endmodule

// File: tb/tb_frame_write_ctrl.sv
// tb_frame_write_ctrl: scoreboard bench with directed and random frames against a behavioural model.
module tb_frame_write_ctrl;
   localparam int DEPTH = 200;
   localparam int AW    = 9;
   localparam int M_FRZ = 0, M_ARM = 1, M_CAP = 2;
   localparam logic [2:0] LIVE = 3'b001, FRZ = 3'b010, SNAP = 3'b100, NONE = 3'b000;
   logic pclk = 1'b0;
   logic rst = 1'b0, vsync = 1'b1, we_in = 1'b0;
   logic cmd_live = 1'b0, cmd_freeze = 1'b0, cmd_snap = 1'b0;
   logic [AW-1:0] addr_in = '0;
   logic wea, frame_done, frozen, overflow;
   logic [AW-1:0] addra;
   logic [7:0] frame_cnt;
   int n_chk = 0, n_fail = 0, n_wea = 0, n_done = 0, n0, d0;
   bit mon_en = 1'b0;
   logic [AW-1:0] exp_wr[$];
   int exp_done[$];
   int m_st, exp_cnt;
   bit m_live, m_more, m_vs, m_skip, exp_frozen, exp_ovf;

   frame_write_ctrl #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
      .pclk(pclk), .rst(rst), .vsync(vsync), .we_in(we_in), .addr_in(addr_in),
      .cmd_live(cmd_live), .cmd_freeze(cmd_freeze), .cmd_snap(cmd_snap),
      .wea(wea), .addra(addra), .frame_done(frame_done), .frozen(frozen),
      .overflow(overflow), .frame_cnt(frame_cnt)
   );

   always #5 pclk = ~pclk;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_st = M_ARM; m_live = 1'b1; m_more = 1'b0; m_vs = 1'b1; m_skip = 1'b1;
      exp_frozen = 1'b0; exp_ovf = 1'b0; exp_cnt = 0;
   endtask

   // Behaviour of one pclk edge given the inputs currently driven.
   task automatic model_step();
      bit fall, rise, bad;
      fall = m_vs && !vsync;
      rise = !m_vs && vsync;
      m_vs = vsync;
      if (m_skip) begin fall = 0; rise = 0; m_skip = 0; end
      bad = 0;
      if (we_in && m_st == M_CAP) begin
         if (int'(addr_in) < DEPTH) exp_wr.push_back(addr_in);
         else bad = 1;
      end
      exp_frozen = (m_st == M_FRZ);
      if (cmd_freeze) begin
         m_live = 0; m_more = 0;
         if (m_st == M_ARM) m_st = M_FRZ;
      end else if (cmd_snap) begin
         m_live = 0; exp_ovf = 0;
         if (m_st == M_FRZ) m_st = M_ARM;
         else if (m_st == M_CAP) m_more = 1;
      end else if (cmd_live) begin
         m_live = 1; m_more = 0; exp_ovf = 0;
         if (m_st == M_FRZ) m_st = M_ARM;
      end
      if (bad) exp_ovf = 1;
      if (fall && m_st == M_ARM) m_st = M_CAP;
      else if (rise && m_st == M_CAP) begin
         exp_cnt = (exp_cnt + 1) % 256;
         exp_done.push_back(exp_cnt);
         m_st = (m_live || m_more) ? M_ARM : M_FRZ;
         m_more = 0;
      end
   endtask

   always begin
      @(posedge pclk);
      #1;
      if (mon_en) begin
         if (wea) begin
            n_wea++;
            if (exp_wr.size() == 0) check("wea_unexpected", 32'(wea), 0);
            else check("addra", 32'(addra), 32'(exp_wr.pop_front()));
         end
         if (frame_done) begin
            n_done++;
            if (exp_done.size() == 0) check("done_unexpected", 32'(frame_done), 0);
            else check("done_cnt", 32'(frame_cnt), 32'(exp_done.pop_front()));
         end
         check("frozen", 32'(frozen), 32'(exp_frozen));
         check("overflow", 32'(overflow), 32'(exp_ovf));
         check("frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
      end
   end

   task automatic cyc(bit vs, bit we, logic [AW-1:0] a, logic [2:0] m);
      @(negedge pclk);
      vsync = vs; we_in = we; addr_in = a;
      cmd_live = m[0]; cmd_freeze = m[1]; cmd_snap = m[2];
      model_step();
   endtask

   task automatic do_reset();
      @(negedge pclk);
      rst = 1'b1;
      model_reset();
      #1;
      check("rst_wea", 32'(wea), 0);
      check("rst_addra", 32'(addra), 0);
      check("rst_done", 32'(frame_done), 0);
      check("rst_frozen", 32'(frozen), 0);
      check("rst_overflow", 32'(overflow), 0);
      check("rst_cnt", 32'(frame_cnt), 0);
      mon_en = 1'b1;
      repeat (2) @(negedge pclk);
      rst = 1'b0;
      model_step();
   endtask

   // Cycle 0 is the vsync fall (its write must be dropped); cycles 1..nw write base+i-1.
   task automatic frame(int nw, int base, bit rnd, logic [2:0] m, int at);
      for (int i = 0; i <= nw; i++) begin
         logic [AW-1:0] a;
         a = AW'(base + ((i == 0) ? 0 : i - 1));
         if (rnd && i != at) a = AW'($urandom_range(0, DEPTH + 40));
         cyc(1'b0, 1'b1, a, (i == at) ? m : NONE);
      end
   endtask

   task automatic blank(int n, logic [2:0] m, int at);
      for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, '0, (i == at) ? m : NONE);
   endtask

   initial begin
      model_reset();
      do_reset();
      blank(5, NONE, -1);
      n0 = n_wea; d0 = n_done;
      repeat (3) begin frame(100, 0, 0, NONE, -1); blank(10, NONE, -1); end
      check("s1_wea", n_wea - n0, 300);
      check("s1_done", n_done - d0, 3);
      check("s1_cnt", 32'(frame_cnt), 3);
      check("s1_frozen", 32'(frozen), 0);
      n0 = n_wea;
      frame(100, 0, 0, NONE, -1); blank(10, NONE, -1);
      frame(100, 0, 0, FRZ, 50); blank(10, NONE, -1);
      frame(100, 0, 0, NONE, -1); blank(10, NONE, -1);
      check("s2_wea", n_wea - n0, 200);
      check("s2_frozen", 32'(frozen), 1);
      n0 = n_wea;
      blank(10, SNAP, 3); frame(100, 0, 0, NONE, -1); blank(10, NONE, -1);
      frame(100, 0, 0, NONE, -1); blank(10, NONE, -1);
      check("s3a_wea", n_wea - n0, 100);
      check("s3a_frozen", 32'(frozen), 1);
      n0 = n_wea;
      blank(10, SNAP, 3); frame(100, 0, 0, SNAP, 50); blank(10, NONE, -1);
      frame(100, 0, 0, NONE, -1); blank(10, NONE, -1);
      frame(100, 0, 0, NONE, -1); blank(10, NONE, -1);
      check("s3b_wea", n_wea - n0, 200);
      check("s3b_frozen", 32'(frozen), 1);
      n0 = n_wea;
      blank(10, LIVE, 3); frame(100, DEPTH - 50, 0, NONE, -1); blank(10, NONE, -1);
      check("s4_wea", n_wea - n0, 50);
      check("s4_ovf", 32'(overflow), 1);
      frame(100, 0, 0, NONE, -1); blank(10, NONE, -1);
      check("s4_ovf_sticky", 32'(overflow), 1);
      blank(10, SNAP, 3);
      check("s4_ovf_clr", 32'(overflow), 0);
      frame(100, 0, 0, NONE, -1); blank(10, NONE, -1);
      n0 = n_wea;
      blank(10, LIVE, 3); frame(100, 0, 0, FRZ, 0); blank(10, NONE, -1);
      check("s5_wea", n_wea - n0, 0);
      check("s5_frozen", 32'(frozen), 1);
      blank(10, LIVE, 3);
      n0 = n_wea;
      frame(40, 0, 0, NONE, -1);
      do_reset();
      for (int i = 0; i < 60; i++) cyc(1'b0, 1'b1, AW'(40 + i), NONE);
      blank(10, NONE, -1);
      check("s6_wea", n_wea - n0, 40);
      check("s6_cnt", 32'(frame_cnt), 0);
      n0 = n_wea;
      frame(100, 0, 0, NONE, -1); blank(10, NONE, -1);
      check("s6_next_wea", n_wea - n0, 100);
      check("s6_next_cnt", 32'(frame_cnt), 1);
      repeat (255) begin frame(2, 0, 0, NONE, -1); blank(2, NONE, -1); end
      check("wrap_cnt", 32'(frame_cnt), 0);
      frame(2, 0, 0, NONE, -1); blank(3, NONE, -1);
      check("wrap_cnt_next", 32'(frame_cnt), 1);
      repeat (60) begin
         int nw;
         logic [2:0] m1, m2;
         nw = $urandom_range(4, 30);
         m1 = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : NONE;
         m2 = ($urandom_range(0, 1) == 0) ? 3'($urandom_range(1, 7)) : NONE;
         frame(nw, 0, 1, m1, $urandom_range(0, nw));
         blank($urandom_range(3, 8), m2, $urandom_range(0, 2));
      end
      blank(5, NONE, -1);
      check("wr_queue_empty", exp_wr.size(), 0);
      check("done_queue_empty", exp_done.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
